// File: rtl/top_if.sv
// Serial receive bundle: the raw asynchronous line plus the decoded-byte outputs.
//   uart_rx : idle-high 8N1 serial line, LSB first (driven by master)
//   ready   : one-clock strobe announcing a fresh byte on data (driven by slave)
//   data    : last validly received byte (driven by slave)
interface top_if;
  logic       uart_rx;
  logic       ready;
  logic [7:0] data;

  modport master (output uart_rx, input ready, input data);
  modport slave  (input uart_rx, output ready, output data);
endinterface

// File: rtl/top.sv
// 8N1 UART receiver with mid-bit sampling and framing-error recovery.
//   clk  : system clock, rising edge
//   rst  : asynchronous, active-high reset
//   bus  : top_if.slave -- uart_rx in, ready/data out
// Parameters: CLK_HZ, BAUD; CLKS_PER_BIT = CLK_HZ/BAUD (truncated).
module top #(
  parameter int unsigned CLK_HZ = 12_000_000,
  parameter int unsigned BAUD   = 9600
) (
  input  logic clk,
  input  logic rst,
  top_if.slave bus
);

  localparam int unsigned CLKS_PER_BIT = CLK_HZ / BAUD;
  localparam int unsigned HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int unsigned CW           = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;

  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;
  logic          rx_m;
  logic          rx_s;

  // Two-flop synchronizer; resets to the idle (high) line level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= bus.uart_rx;
      rx_s <= rx_m;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shift     <= '0;
      bus.data  <= '0;
      bus.ready <= 1'b0;
    end else begin
      bus.ready <= 1'b0;
      case (state)
        IDLE: begin
          if (!rx_s) begin
            state <= START;
            cnt   <= '0;
          end
        end

        // Half a bit in: a still-low line confirms the start bit, and all
        // later samples then land mid-bit at whole-bit spacing.
        START: begin
          if (cnt == HALF_LAST) begin
            cnt     <= '0;
            bit_idx <= '0;
            state   <= rx_s ? IDLE : DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        DATA: begin
          if (cnt == BIT_LAST) begin
            cnt     <= '0;
            shift   <= {rx_s, shift[7:1]};
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == 3'd7) begin
              state <= STOP;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        // Return straight to IDLE after a good stop sample so a start edge
        // immediately following is caught with no dead time.
        STOP: begin
          if (cnt == BIT_LAST) begin
            cnt <= '0;
            if (rx_s) begin
              bus.data  <= shift;
              bus.ready <= 1'b1;
              state     <= IDLE;
            end else begin
              state <= WAIT_IDLE;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        WAIT_IDLE: begin
          if (rx_s) begin
            state <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_top.sv
// Directed bench for the UART receiver. Uses BAUD=700_000 at 12 MHz so that
// CLKS_PER_BIT = 17 (truncated from 17.14) and frames stay short.
module tb_top;

  localparam int unsigned CPB = 17;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;
  int   ncyc;
  int   hi_cycles;
  int   last_rdy;
  int   t0;
  int   hi_before;

  top_if bus ();

  top #(.CLK_HZ(12_000_000), .BAUD(700_000)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #42 clk = ~clk;

  always @(negedge clk) begin
    ncyc = ncyc + 1;
    if (bus.ready === 1'b1) begin
      hi_cycles = hi_cycles + 1;
      last_rdy  = ncyc;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp = n_cmp + 1;
    assert (obs === exp) else begin
      n_err = n_err + 1;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Caller is always aligned to 1 ns after a falling clock edge.
  task automatic drive_bit(input logic v);
    bus.uart_rx = v;
    repeat (CPB) @(negedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    bus.uart_rx = 1'b1;
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    t0 = ncyc;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop);
  endtask

  initial begin
    n_cmp     = 0;
    n_err     = 0;
    ncyc      = 0;
    hi_cycles = 0;
    last_rdy  = 0;
    t0        = 0;
    bus.uart_rx = 1'b1;
    rst = 1'b1;
    #10;
    check("reset_data", {24'h0, bus.data}, 32'h00);
    check("reset_ready", {31'h0, bus.ready}, 32'h0);

    repeat (3) @(negedge clk);
    #1;
    rst = 1'b0;

    // Idle line: nothing received.
    idle(100);
    check("idle_pulses", hi_cycles, 0);
    check("idle_data", {24'h0, bus.data}, 32'h00);

    // Frame 1 (0x45) immediately followed by frame 2 (0x55).
    send_frame(8'h45, 1'b1);
    check("f1_pulses", hi_cycles, 1);
    check("f1_data", {24'h0, bus.data}, 32'h45);
    // Falling edge to ready: 2 sync + 1 + 8 + 9*17 = 164 cycles (9.5 bits + 3).
    check("f1_latency_in_range", {31'h0, ((last_rdy - t0) >= 164) && ((last_rdy - t0) <= 165)}, 32'h1);
    send_frame(8'h55, 1'b1);
    check("f2_pulses", hi_cycles, 2);
    check("f2_data", {24'h0, bus.data}, 32'h55);
    check("f2_latency_in_range", {31'h0, ((last_rdy - t0) >= 164) && ((last_rdy - t0) <= 165)}, 32'h1);

    // Glitch shorter than half a bit, then a real 0xA5 frame.
    idle(20);
    bus.uart_rx = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    idle(40);
    check("glitch_pulses", hi_cycles, 2);
    check("glitch_data", {24'h0, bus.data}, 32'h55);
    send_frame(8'hA5, 1'b1);
    check("a5_pulses", hi_cycles, 3);
    check("a5_data", {24'h0, bus.data}, 32'hA5);

    // Framing error: stop bit low, line held low a while longer.
    idle(10);
    send_frame(8'h3C, 1'b0);
    repeat (30) @(negedge clk);
    #1;
    check("ferr_pulses", hi_cycles, 3);
    check("ferr_data", {24'h0, bus.data}, 32'hA5);
    idle(10);
    send_frame(8'h96, 1'b1);
    check("after_ferr_pulses", hi_cycles, 4);
    check("after_ferr_data", {24'h0, bus.data}, 32'h96);

    // Reset in the middle of data bit 3 of a 0x77 frame.
    idle(10);
    drive_bit(1'b0);
    for (int i = 0; i < 3; i++) drive_bit(1'b1);
    bus.uart_rx = 1'b0;
    repeat (5) @(negedge clk);
    #1;
    hi_before = hi_cycles;
    rst = 1'b1;
    #1;
    check("midrst_data", {24'h0, bus.data}, 32'h00);
    check("midrst_ready", {31'h0, bus.ready}, 32'h0);
    bus.uart_rx = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    rst = 1'b0;
    idle(10);
    check("midrst_no_pulse", hi_cycles, hi_before);
    send_frame(8'hC3, 1'b1);
    check("post_rst_pulses", hi_cycles, 5);
    check("post_rst_data", {24'h0, bus.data}, 32'hC3);

    // Data must hold with the line idle.
    idle(60);
    check("hold_data", {24'h0, bus.data}, 32'hC3);
    check("final_pulses", hi_cycles, 5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/top.md
TOP -- requirements
Module: top

Interface
REQ-001 CLK_HZ, 12_000_000, system clock frequency in Hz (an 84 ns period is treated as 12 MHz).
REQ-002 BAUD, 9600, serial bit rate; CLKS_PER_BIT = CLK_HZ/BAUD (1250 at defaults), integer division, truncated.
REQ-003 clk  input  1  system clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset; asynchronous, active-high.
REQ-005 uart_rx  input  1  asynchronous serial line; idles high; 8N1 format, LSB first.
REQ-006 ready  output  1  one-clock pulse marking a newly received valid byte on data.
REQ-007 data  output  8  last validly received byte.

Function
REQ-008 uart_rx SHALL pass through a 2-flop synchronizer, both flops reset to 1; all logic SHALL use the synchronized value (rx_s).
REQ-009 The FSM SHALL have states IDLE, START, DATA, STOP, and WAIT_IDLE.
REQ-010 IDLE: when rx_s = 0, go to START and clear the bit-timing counter.
REQ-011 START: after CLKS_PER_BIT/2 cycles (625), sample rx_s.
- Sample 0: go to DATA with the counter cleared.
- Sample 1: treat as a glitch and return to IDLE, with no output change.
REQ-012 DATA: sample rx_s every CLKS_PER_BIT cycles, mid-bit.
- Shift each sample into an 8-bit shift register LSB first (first data bit lands at bit 0).
- After the 8th sample, go to STOP.
REQ-013 STOP: sample rx_s CLKS_PER_BIT cycles after the 8th data sample.
- Sample 1: load data from the shift register and pulse ready high for exactly one cycle, on the cycle after the sample; go to IDLE.
- Sample 0 (framing error): leave data unchanged, no ready pulse; go to WAIT_IDLE.
REQ-014 WAIT_IDLE: stay until rx_s = 1, then go to IDLE.
REQ-015 Sample points, measured from the cycle START is entered:
- start bit: 625 cycles
- data bit k (k = 0..7): 625 + 1250·(k+1) cycles
- stop bit: 625 + 1250·9 cycles
REQ-016 Latency from the uart_rx falling edge to the ready pulse SHALL be 9.5 bit times + 3 clk, ±1 clk.
REQ-017 data SHALL hold its value between valid bytes; ready SHALL be 0 at all other times.
REQ-018 A start edge arriving immediately after a valid stop sample SHALL be accepted with no dead bit time (back-to-back frames).
REQ-019 The bit-timing counter SHALL be wide enough for CLKS_PER_BIT-1 (11 bits at defaults) and SHALL never wrap within a bit.
REQ-020 uart_rx activity in any state other than IDLE/WAIT_IDLE SHALL NOT restart frame timing.

Reset
REQ-021 While rst = 1, regardless of clk:
- state = IDLE
- counters and shift register = 0
- synchronizer flops = 1
- data = 8'h00
- ready = 0
REQ-022 Reset asserted mid-frame SHALL discard the partial byte.
REQ-023 After rst deasserts, the first low seen in IDLE SHALL be treated as a start bit.

Verification
REQ-024 Idle: rst = 0, line held high for 100 µs -> ready never asserts; data = 8'h00.
REQ-025 Single frame at 9600 baud (104167 ns/bit): start at 100 µs, bits 1,0,1,0,0,0,1,0 (LSB first), stop = 1 -> one ready pulse ~1.09 ms into sim; data = 8'h45.
REQ-026 Back-to-back second frame: bits 1,0,1,0,1,0,1,0 sent immediately after frame 1's stop bit -> second ready pulse ~2.13 ms; data = 8'h55; exactly 2 pulses in a 5 ms run.
REQ-027 Glitch: line low for 20 µs, then high -> no ready pulse; FSM back in IDLE; a subsequent 8'hA5 frame is received correctly.
REQ-028 Framing error: frame with stop bit = 0 -> no ready pulse; data keeps its previous value; the next valid frame is received after the line returns high.
REQ-029 Reset mid-frame: rst pulsed during data bit 3 -> data = 8'h00 and ready = 0 immediately; the next full frame decodes correctly.
